// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle processor: opcodes, ALU ops,
// controller state encoding and datapath mux select encodings.
// Imported by the controller, its watchdog, the ALU and the proc top.
package proc_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    // ALU operation codes (same space as R-type funct)
    localparam logic [5:0] ALU_ADD = 6'h20;
    localparam logic [5:0] ALU_SUB = 6'h22;

    // Controller state encoding, visible on oState
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;
    localparam logic [2:0] ST_FAULT  = 3'd6;

    // PC source select
    localparam logic [1:0] PCSEL_INC  = 2'd0;  // ALU result, PC+4
    localparam logic [1:0] PCSEL_Z    = 2'd1;  // Z, branch target
    localparam logic [1:0] PCSEL_JUMP = 2'd2;  // {PC[31:28], IR[25:0], 2'b00}

    // ALU operand selects
    localparam logic       ALUA_PC      = 1'b0;
    localparam logic       ALUA_RA      = 1'b1;
    localparam logic [1:0] ALUB_RB      = 2'd0;
    localparam logic [1:0] ALUB_FOUR    = 2'd1;
    localparam logic [1:0] ALUB_IMM     = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

    // Memory address source
    localparam logic ADDR_PC = 1'b0;
    localparam logic ADDR_Z  = 1'b1;

    // Bundle of every control line the controller drives into the datapath
    typedef struct packed {
        logic       ir_en;
        logic       mdr_en;
        logic       mem_rd;
        logic       mem_wr;
        logic       addr_sel;
        logic       pc_en;
        logic [1:0] pc_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [5:0] alu_op;
        logic       z_en;
        logic       rf_write;
        logic       rf_dst_sel;
        logic       rf_data_sel;
    } ctrl_t;

    // True for every opcode the controller knows how to sequence
    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE,
            OP_ADDI, OP_LW, OP_SW, OP_HALT: op_legal = 1'b1;
            default:                        op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/proc_ctrl_wdog.sv
// Memory-request watchdog: counts stalled request cycles, flags expiry.
// Latency: expire_o is combinational from the registered count.
// Backpressure: none; clr_i has priority over inc_i, count saturates at TIMEOUT-1.
module proc_ctrl_wdog
    import proc_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on state change, otherwise step while the request stalls
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/proc_ctrl.sv
// Multicycle controller: decodes IR and sequences the datapath per instruction.
// Latency: 3 (branch/J), 4 (R-type/ADDI/SW), 5 (LW) cycles plus memory wait cycles.
// Backpressure: memory requests are held stable until iMemReady; watchdog forces FAULT.
module proc_ctrl
    import proc_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [31:0] iIR,
    input  logic        iMemReady,
    input  logic        iALUZero,
    output logic        oIR_en,
    output logic        oMDR_en,
    output logic        oMemRead,
    output logic        oMemWrite,
    output logic        oAddrSel,
    output logic        oPC_en,
    output logic [1:0]  oPCSel,
    output logic        oALUSrcA,
    output logic [1:0]  oALUSrcB,
    output logic [5:0]  oALUOp,
    output logic        oZ_en,
    output logic        oRFWrite,
    output logic        oRFDstSel,
    output logic        oRFDataSel,
    output logic [2:0]  oState,
    output logic        oFault
);

    logic [2:0] state_q;
    logic [2:0] state_d;
    ctrl_t      ctrl;
    logic       wd_inc;
    logic       wd_expire;
    logic       wd_clr;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_lw;

    assign opcode = iIR[31:26];
    assign funct  = iIR[5:0];
    assign is_lw  = (opcode == OP_LW);

    // Register specifiers and immediate are consumed by the datapath only
    logic unused_ir_bits;
    assign unused_ir_bits = ^iIR[25:6];

    // Watchdog restarts whenever the FSM moves to a different state
    assign wd_clr = (state_d != state_q);

    proc_ctrl_wdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wdog (
        .clk_i    (iClk),
        .rst_i    (iRst),
        .clr_i    (wd_clr),
        .inc_i    (wd_inc),
        .expire_o (wd_expire)
    );

    // Next-state and control decode; all strobes default low
    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        wd_inc  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                ctrl.mem_rd    = 1'b1;
                ctrl.addr_sel  = ADDR_PC;
                ctrl.alu_src_a = ALUA_PC;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                if (iMemReady) begin
                    // Ready beats the watchdog on the same cycle
                    ctrl.ir_en  = 1'b1;
                    ctrl.pc_en  = 1'b1;
                    ctrl.pc_sel = PCSEL_INC;
                    state_d     = ST_DECODE;
                end else begin
                    wd_inc = 1'b1;
                    if (wd_expire) begin
                        state_d = ST_FAULT;
                    end
                end
            end

            ST_DECODE: begin
                // Precompute the branch target into Z while decoding
                ctrl.alu_src_a = ALUA_PC;
                ctrl.alu_src_b = ALUB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
                ctrl.z_en      = 1'b1;
                state_d        = op_legal(opcode) ? ST_EXEC : ST_FAULT;
            end

            ST_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        ctrl.alu_src_a = ALUA_RA;
                        ctrl.alu_src_b = ALUB_RB;
                        ctrl.alu_op    = funct;
                        ctrl.z_en      = 1'b1;
                        state_d        = ST_WB;
                    end
                    OP_ADDI: begin
                        ctrl.alu_src_a = ALUA_RA;
                        ctrl.alu_src_b = ALUB_IMM;
                        ctrl.alu_op    = ALU_ADD;
                        ctrl.z_en      = 1'b1;
                        state_d        = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        ctrl.alu_src_a = ALUA_RA;
                        ctrl.alu_src_b = ALUB_IMM;
                        ctrl.alu_op    = ALU_ADD;
                        ctrl.z_en      = 1'b1;
                        state_d        = ST_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        // Z still holds the target from DECODE; compare RA-RB
                        ctrl.alu_src_a = ALUA_RA;
                        ctrl.alu_src_b = ALUB_RB;
                        ctrl.alu_op    = ALU_SUB;
                        ctrl.pc_sel    = PCSEL_Z;
                        ctrl.pc_en     = (opcode == OP_BEQ) ? iALUZero : !iALUZero;
                        state_d        = ST_FETCH;
                    end
                    OP_J: begin
                        ctrl.pc_en  = 1'b1;
                        ctrl.pc_sel = PCSEL_JUMP;
                        state_d     = ST_FETCH;
                    end
                    OP_HALT: begin
                        state_d = ST_HALT;
                    end
                    default: begin
                        // Unreachable: DECODE filters illegal opcodes
                        state_d = ST_FAULT;
                    end
                endcase
            end

            ST_MEM: begin
                ctrl.addr_sel = ADDR_Z;
                ctrl.mem_rd   = is_lw;
                ctrl.mem_wr   = !is_lw;
                if (iMemReady) begin
                    ctrl.mdr_en = is_lw;
                    state_d     = is_lw ? ST_WB : ST_FETCH;
                end else begin
                    wd_inc = 1'b1;
                    if (wd_expire) begin
                        state_d = ST_FAULT;
                    end
                end
            end

            ST_WB: begin
                ctrl.rf_write = 1'b1;
                if (is_lw) begin
                    ctrl.rf_data_sel = 1'b1;
                    ctrl.rf_dst_sel  = 1'b0;
                end else if (opcode == OP_RTYPE) begin
                    ctrl.rf_data_sel = 1'b0;
                    ctrl.rf_dst_sel  = 1'b1;
                end else begin
                    ctrl.rf_data_sel = 1'b0;
                    ctrl.rf_dst_sel  = 1'b0;
                end
                state_d = ST_FETCH;
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            ST_FAULT: begin
                state_d = ST_FAULT;
            end

            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // State register; reset aborts any instruction in flight
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Output drive; everything held low while reset is asserted
    always_comb begin
        oIR_en     = 1'b0;
        oMDR_en    = 1'b0;
        oMemRead   = 1'b0;
        oMemWrite  = 1'b0;
        oAddrSel   = 1'b0;
        oPC_en     = 1'b0;
        oPCSel     = 2'd0;
        oALUSrcA   = 1'b0;
        oALUSrcB   = 2'd0;
        oALUOp     = 6'd0;
        oZ_en      = 1'b0;
        oRFWrite   = 1'b0;
        oRFDstSel  = 1'b0;
        oRFDataSel = 1'b0;
        oState     = 3'd0;
        oFault     = 1'b0;
        if (!iRst) begin
            oIR_en     = ctrl.ir_en;
            oMDR_en    = ctrl.mdr_en;
            oMemRead   = ctrl.mem_rd;
            oMemWrite  = ctrl.mem_wr;
            oAddrSel   = ctrl.addr_sel;
            oPC_en     = ctrl.pc_en;
            oPCSel     = ctrl.pc_sel;
            oALUSrcA   = ctrl.alu_src_a;
            oALUSrcB   = ctrl.alu_src_b;
            oALUOp     = ctrl.alu_op;
            oZ_en      = ctrl.z_en;
            oRFWrite   = ctrl.rf_write;
            oRFDstSel  = ctrl.rf_dst_sel;
            oRFDataSel = ctrl.rf_data_sel;
            oState     = state_q;
            oFault     = (state_q == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_proc_ctrl.sv
// Directed bench for proc_ctrl: per-cycle vector table plus watchdog sequence.
module tb_proc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ir = 32'h0;
    logic        rdy = 1'b0;
    logic        zero = 1'b0;

    logic        ir_en, mdr_en, mrd, mwr, asel, pc_en, srca, z_en, rfw, dst, dsel, flt;
    logic [1:0]  pcsel, srcb;
    logic [5:0]  aluop;
    logic [2:0]  st;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    proc_ctrl #(.TIMEOUT(16), .CNT_W(8)) dut (
        .iClk       (clk),
        .iRst       (rst),
        .iIR        (ir),
        .iMemReady  (rdy),
        .iALUZero   (zero),
        .oIR_en     (ir_en),
        .oMDR_en    (mdr_en),
        .oMemRead   (mrd),
        .oMemWrite  (mwr),
        .oAddrSel   (asel),
        .oPC_en     (pc_en),
        .oPCSel     (pcsel),
        .oALUSrcA   (srca),
        .oALUSrcB   (srcb),
        .oALUOp     (aluop),
        .oZ_en      (z_en),
        .oRFWrite   (rfw),
        .oRFDstSel  (dst),
        .oRFDataSel (dsel),
        .oState     (st),
        .oFault     (flt)
    );

    // Strobe bit positions in the packed comparison word
    localparam logic [10:0] IRE  = 11'h001;
    localparam logic [10:0] MDRE = 11'h002;
    localparam logic [10:0] MRD  = 11'h004;
    localparam logic [10:0] MWR  = 11'h008;
    localparam logic [10:0] ASEL = 11'h010;
    localparam logic [10:0] PCE  = 11'h020;
    localparam logic [10:0] ZE   = 11'h040;
    localparam logic [10:0] RFW  = 11'h080;
    localparam logic [10:0] DST  = 11'h100;
    localparam logic [10:0] DSEL = 11'h200;
    localparam logic [10:0] FLT  = 11'h400;
    localparam logic [10:0] NONE = 11'h000;

    localparam logic [5:0] ADD = 6'h20;
    localparam logic [5:0] SUB = 6'h22;

    localparam logic [31:0] I_RT   = 32'h012A4020;
    localparam logic [31:0] I_LW   = 32'h8C880004;
    localparam logic [31:0] I_SW   = 32'hAC880008;
    localparam logic [31:0] I_BEQ  = 32'h11090003;
    localparam logic [31:0] I_J    = 32'h08000010;
    localparam logic [31:0] I_ADDI = 32'h21280005;
    localparam logic [31:0] I_ILL  = 32'hF8000000;
    localparam logic [31:0] I_HLT  = 32'hFC000000;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        zero;
        logic [31:0] ir;
        logic [2:0]  st;
        logic [10:0] stb;
        logic [1:0]  pcsel;
        logic        chk_alu;
        logic        srca;
        logic [1:0]  srcb;
        logic [5:0]  aluop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input logic r, input logic rd, input logic z,
                                 input logic [31:0] i, input logic [2:0] s,
                                 input logic [10:0] sb, input logic [1:0] ps,
                                 input logic ca, input logic sa,
                                 input logic [1:0] sbb, input logic [5:0] op);
        vec_t v;
        v.rst = r; v.rdy = rd; v.zero = z; v.ir = i; v.st = s; v.stb = sb;
        v.pcsel = ps; v.chk_alu = ca; v.srca = sa; v.srcb = sbb; v.aluop = op;
        return v;
    endfunction

    // Shorthands for the two states every instruction shares
    function automatic vec_t v_fetch(input logic [31:0] i);
        return mkv(0, 1, 0, i, 3'd0, IRE | PCE | MRD, 2'd0, 1, 0, 2'd1, ADD);
    endfunction
    function automatic vec_t v_dec(input logic [31:0] i);
        return mkv(0, 1, 0, i, 3'd1, ZE, 2'd0, 1, 0, 2'd3, ADD);
    endfunction

    function automatic logic [10:0] act_stb();
        return (ir_en ? IRE : NONE) | (mdr_en ? MDRE : NONE) | (mrd ? MRD : NONE) |
               (mwr ? MWR : NONE) | (asel ? ASEL : NONE) | (pc_en ? PCE : NONE) |
               (z_en ? ZE : NONE) | (rfw ? RFW : NONE) | (dst ? DST : NONE) |
               (dsel ? DSEL : NONE) | (flt ? FLT : NONE);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        // Reset, then R-type ADD
        vecs.push_back(mkv(1, 1, 0, I_RT, 3'd0, NONE, 2'd0, 1, 0, 2'd0, 6'd0));
        vecs.push_back(v_fetch(I_RT));
        vecs.push_back(v_dec(I_RT));
        vecs.push_back(mkv(0, 1, 0, I_RT, 3'd2, ZE, 2'd0, 1, 1, 2'd0, ADD));
        vecs.push_back(mkv(0, 1, 0, I_RT, 3'd4, RFW | DST, 2'd0, 0, 0, 2'd0, 6'd0));
        // LW with three wait cycles in MEM (8 cycles total)
        vecs.push_back(v_fetch(I_LW));
        vecs.push_back(v_dec(I_LW));
        vecs.push_back(mkv(0, 1, 0, I_LW, 3'd2, ZE, 2'd0, 1, 1, 2'd2, ADD));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mkv(0, 0, 0, I_LW, 3'd3, MRD | ASEL, 2'd0, 0, 0, 2'd0, 6'd0));
        vecs.push_back(mkv(0, 1, 0, I_LW, 3'd3, MRD | ASEL | MDRE, 2'd0, 0, 0, 2'd0, 6'd0));
        vecs.push_back(mkv(0, 1, 0, I_LW, 3'd4, RFW | DSEL, 2'd0, 0, 0, 2'd0, 6'd0));
        // BEQ taken, then BEQ not taken
        vecs.push_back(v_fetch(I_BEQ));
        vecs.push_back(v_dec(I_BEQ));
        vecs.push_back(mkv(0, 1, 1, I_BEQ, 3'd2, PCE, 2'd1, 1, 1, 2'd0, SUB));
        vecs.push_back(v_fetch(I_BEQ));
        vecs.push_back(v_dec(I_BEQ));
        vecs.push_back(mkv(0, 1, 0, I_BEQ, 3'd2, NONE, 2'd1, 1, 1, 2'd0, SUB));
        // Jump
        vecs.push_back(v_fetch(I_J));
        vecs.push_back(v_dec(I_J));
        vecs.push_back(mkv(0, 1, 0, I_J, 3'd2, PCE, 2'd2, 0, 0, 2'd0, 6'd0));
        // ADDI
        vecs.push_back(v_fetch(I_ADDI));
        vecs.push_back(v_dec(I_ADDI));
        vecs.push_back(mkv(0, 1, 0, I_ADDI, 3'd2, ZE, 2'd0, 1, 1, 2'd2, ADD));
        vecs.push_back(mkv(0, 1, 0, I_ADDI, 3'd4, RFW, 2'd0, 0, 0, 2'd0, 6'd0));
        // SW interrupted by reset while in MEM
        vecs.push_back(v_fetch(I_SW));
        vecs.push_back(v_dec(I_SW));
        vecs.push_back(mkv(0, 1, 0, I_SW, 3'd2, ZE, 2'd0, 1, 1, 2'd2, ADD));
        vecs.push_back(mkv(0, 0, 0, I_SW, 3'd3, MWR | ASEL, 2'd0, 0, 0, 2'd0, 6'd0));
        vecs.push_back(mkv(1, 0, 0, I_SW, 3'd0, NONE, 2'd0, 0, 0, 2'd0, 6'd0));
        vecs.push_back(mkv(1, 1, 0, I_SW, 3'd0, NONE, 2'd0, 0, 0, 2'd0, 6'd0));
        vecs.push_back(mkv(0, 0, 0, I_SW, 3'd0, MRD, 2'd0, 1, 0, 2'd1, ADD));
        // Illegal opcode: FAULT after DECODE, sticky
        vecs.push_back(v_fetch(I_ILL));
        vecs.push_back(v_dec(I_ILL));
        vecs.push_back(mkv(0, 1, 0, I_ILL, 3'd6, FLT, 2'd0, 0, 0, 2'd0, 6'd0));
        vecs.push_back(mkv(0, 1, 1, I_ILL, 3'd6, FLT, 2'd0, 0, 0, 2'd0, 6'd0));
        vecs.push_back(mkv(1, 1, 0, I_HLT, 3'd0, NONE, 2'd0, 0, 0, 2'd0, 6'd0));
        // HALT parks until reset
        vecs.push_back(v_fetch(I_HLT));
        vecs.push_back(v_dec(I_HLT));
        vecs.push_back(mkv(0, 1, 0, I_HLT, 3'd2, NONE, 2'd0, 0, 0, 2'd0, 6'd0));
        vecs.push_back(mkv(0, 1, 0, I_HLT, 3'd5, NONE, 2'd0, 0, 0, 2'd0, 6'd0));
        vecs.push_back(mkv(0, 1, 0, I_HLT, 3'd5, NONE, 2'd0, 0, 0, 2'd0, 6'd0));

        // One vector per cycle: drive after the edge, sample on the falling edge
        foreach (vecs[idx]) begin
            rst = vecs[idx].rst; rdy = vecs[idx].rdy;
            zero = vecs[idx].zero; ir = vecs[idx].ir;
            @(negedge clk);
            n_checks++;
            if (st !== vecs[idx].st || act_stb() !== vecs[idx].stb || pcsel !== vecs[idx].pcsel ||
                (vecs[idx].chk_alu && (srca !== vecs[idx].srca || srcb !== vecs[idx].srcb ||
                                       aluop !== vecs[idx].aluop))) begin
                n_fail++;
                $display("FAIL vec%0d: got st=%0d stb=%03h pcsel=%0d a=%0d b=%0d op=%02h expected st=%0d stb=%03h pcsel=%0d a=%0d b=%0d op=%02h",
                         idx, st, act_stb(), pcsel, srca, srcb, aluop,
                         vecs[idx].st, vecs[idx].stb, vecs[idx].pcsel,
                         vecs[idx].srca, vecs[idx].srcb, vecs[idx].aluop);
            end
            @(posedge clk); #1;
        end

        // Watchdog: memory never ready in FETCH
        begin
            int  req_cycles = 0;
            bit  saw_ir_en  = 0;
            bit  reached    = 0;
            rst = 1'b1; rdy = 1'b0; ir = I_RT;
            @(posedge clk); #1;
            rst = 1'b0;
            for (int c = 0; c < 40 && !reached; c++) begin
                @(negedge clk);
                if (ir_en) saw_ir_en = 1;
                if (st == 3'd6) reached = 1;
                else if (st == 3'd0 && mrd) req_cycles++;
                @(posedge clk); #1;
            end
            check("wdog_reached_fault", {31'd0, reached}, 32'd1);
            check("wdog_request_cycles", req_cycles, 32'd16);
            check("wdog_no_ir_en", {31'd0, saw_ir_en}, 32'd0);
            @(negedge clk);
            check("wdog_fault_flag", {31'd0, flt}, 32'd1);
            check("wdog_fault_state", {29'd0, st}, 32'd6);
            // Reset clears the fault
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check("post_reset_state", {29'd0, st}, 32'd0);
            check("post_reset_fault", {31'd0, flt}, 32'd0);
            check("post_reset_memread", {31'd0, mrd}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
